wptr_flag_ctrl: RTL and testbench

//   Write-domain pointer and flag controller for the async FIFO, parametrised in depth.

---
 rtl/wptr_flag_ctrl.sv | 86 ++++++++
 tb/tb_wptr_flag_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/wptr_flag_ctrl.sv
// Write-side pointer/flag controller for an async FIFO: binary+Gray write pointers, full/almost_full/level/overflow.
// Optional macro WPTR_RPTR_SYNC_EN adds a two-flop wclock synchroniser on gray_rptr_in.
module wptr_flag_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int AF_MARGIN  = 1
) (
  input  logic                  wclock,
  input  logic                  wreset,
  input  logic                  w_en,
  input  logic                  clr_ovf,
  input  logic [ADDR_WIDTH:0]   gray_rptr_in,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   bin_wptr,
  output logic [ADDR_WIDTH:0]   gray_wptr,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  overflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH    = PW'(1 << ADDR_WIDTH);
  localparam logic [PW-1:0] AF_LEVEL = PW'((1 << ADDR_WIDTH) - AF_MARGIN);

  logic [PW-1:0] rptr_s;
  logic [PW-1:0] rptr_bin;
  logic          push;
  logic [PW-1:0] bin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] level_next;

`ifdef WPTR_RPTR_SYNC_EN
  logic [PW-1:0] sync1_reg;
  logic [PW-1:0] sync2_reg;

  always_ff @(posedge wclock or posedge wreset) begin
    if (wreset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= gray_rptr_in;
      sync2_reg <= sync1_reg;
    end
  end

  assign rptr_s = sync2_reg;
`else
  assign rptr_s = gray_rptr_in;
`endif

  // Each binary bit is the xor of all Gray bits from the MSB down to it.
  generate
    for (genvar gi = 0; gi < PW; gi++) begin : g_gray2bin
      assign rptr_bin[gi] = ^rptr_s[PW-1:gi];
    end
  endgenerate

  assign push       = w_en & ~full;
  assign bin_next   = bin_wptr + PW'(push);
  assign gray_next  = bin_next ^ (bin_next >> 1);
  assign level_next = bin_next - rptr_bin;
  assign waddr      = bin_wptr[ADDR_WIDTH-1:0];

  always_ff @(posedge wclock or posedge wreset) begin
    if (wreset) begin
      bin_wptr    <= '0;
      gray_wptr   <= '0;
      wlevel      <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      bin_wptr    <= bin_next;
      gray_wptr   <= gray_next;
      wlevel      <= level_next;
      full        <= (level_next == DEPTH);
      almost_full <= (level_next >= AF_LEVEL);
      // A rejected write wins over a simultaneous clear.
      if (w_en && full)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wptr_flag_ctrl.sv
// Scoreboard bench for wptr_flag_ctrl (ADDR_WIDTH=3, AF_MARGIN=1): driver queues expectations, monitor compares.
module tb_wptr_flag_ctrl;

`ifdef WPTR_RPTR_SYNC_EN
  localparam int LEAD = 2;
`else
  localparam int LEAD = 0;
`endif

  logic       wclock = 1'b0;
  logic       wreset;
  logic       w_en;
  logic       clr_ovf;
  logic [3:0] gray_rptr_in;
  logic [2:0] waddr;
  logic [3:0] bin_wptr;
  logic [3:0] gray_wptr;
  logic       full;
  logic       almost_full;
  logic [3:0] wlevel;
  logic       overflow;

  wptr_flag_ctrl #(.ADDR_WIDTH(3), .AF_MARGIN(1)) dut (
    .wclock       (wclock),
    .wreset       (wreset),
    .w_en         (w_en),
    .clr_ovf      (clr_ovf),
    .gray_rptr_in (gray_rptr_in),
    .waddr        (waddr),
    .bin_wptr     (bin_wptr),
    .gray_wptr    (gray_wptr),
    .full         (full),
    .almost_full  (almost_full),
    .wlevel       (wlevel),
    .overflow     (overflow)
  );

  always #5 wclock = ~wclock;

  typedef struct {
    bit       rst;
    bit       w;
    bit       clr;
    logic [3:0] r;
    logic [3:0] eb;
    bit       ef;
    bit       eaf;
    logic [3:0] el;
    bit       eo;
  } row_t;

  typedef struct {
    int         idx;
    logic [3:0] eb;
    bit         ef;
    bit         eaf;
    logic [3:0] el;
    bit         eo;
  } exp_t;

  row_t rows[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add_row(bit rst, bit w, bit clr, int r, int eb,
                                  bit ef, bit eaf, int el, bit eo);
    row_t x;
    x.rst = rst; x.w = w; x.clr = clr; x.r = 4'(r); x.eb = 4'(eb);
    x.ef = ef; x.eaf = eaf; x.el = 4'(el); x.eo = eo;
    rows.push_back(x);
  endfunction

  function automatic logic [3:0] to_gray(logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(string name, int idx, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s row %0d actual %0d required %0d", name, idx, act, req);
    end
  endtask

  // Monitor: one popped expectation per clock edge or reset assertion.
  logic [3:0] prev_gray = 4'd0;
  initial begin
    exp_t e;
    forever begin
      @(posedge wclock or posedge wreset);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("bin_wptr",    e.idx, int'(bin_wptr),    int'(e.eb));
        chk("gray_wptr",   e.idx, int'(gray_wptr),   int'(to_gray(e.eb)));
        chk("waddr",       e.idx, int'(waddr),       int'(e.eb[2:0]));
        chk("full",        e.idx, int'(full),        int'(e.ef));
        chk("almost_full", e.idx, int'(almost_full), int'(e.eaf));
        chk("wlevel",      e.idx, int'(wlevel),      int'(e.el));
        chk("overflow",    e.idx, int'(overflow),    int'(e.eo));
        $display("row %0d bin=%0d gray=%b full=%0b af=%0b lvl=%0d ovf=%0b",
                 e.idx, bin_wptr, gray_wptr, full, almost_full, wlevel, overflow);
      end
      if (wreset !== 1'b1) begin
        checks++;
        if ($countones(gray_wptr ^ prev_gray) > 1) begin
          errors++;
          $display("FAIL gray_step actual %b->%b required one bit change", prev_gray, gray_wptr);
        end
      end
      prev_gray = gray_wptr;
    end
  end

  // Driver
  initial begin
    int b, r, nb, nr, lvl;
    bit f, o, w, clr, adv, push, no;
    row_t ri;
    exp_t e;
    int li;
    logic [3:0] rp;

    wreset = 1'b1; w_en = 1'b0; clr_ovf = 1'b0; gray_rptr_in = 4'd0;

    // Reset state, then five writes and a mid-stream reset
    add_row(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) add_row(0, 1, 0, 0, k, 0, 0, k, 0);
    add_row(1, 1, 0, 0, 0, 0, 0, 0, 0);
    add_row(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Fill with read pointer at 0: 9 requests
    for (int k = 1; k <= 6; k++) add_row(0, 1, 0, 0, k, 0, 0, k, 0);
    add_row(0, 1, 0, 0, 7, 0, 1, 7, 0);
    add_row(0, 1, 0, 0, 8, 1, 1, 8, 0);
    add_row(0, 1, 0, 0, 8, 1, 1, 8, 1);
    // Overflow set beats clear; then plain clear
    add_row(0, 1, 1, 0, 8, 1, 1, 8, 1);
    add_row(0, 0, 1, 0, 8, 1, 1, 8, 0);
    // Drain response: read pointer 2 (Gray 0011)
    add_row(0, 0, 0, 2, 8, 0, 0, 6, 0);
    add_row(0, 0, 0, 2, 8, 0, 0, 6, 0);
    add_row(0, 0, 0, 6, 8, 0, 0, 2, 0);
    // Wrap: reader stays 2 behind for 20 writes, crossing 15 -> 0
    for (int k = 0; k < 20; k++)
      add_row(0, 1, 0, (8 + k - 1) & 15, (8 + k + 1) & 15, 0, 0, 2, 0);
    // Random traffic with a word-count model
    b = 12; r = 11; f = 1'b0; o = 1'b0;
    for (int k = 0; k < 60; k++) begin
      w    = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 7) == 0);
      adv  = ($urandom_range(0, 2) == 0) && (((b - r) & 15) != 0);
      nr   = (r + int'(adv)) & 15;
      push = w && !f;
      nb   = (b + int'(push)) & 15;
      lvl  = (nb - nr) & 15;
      no   = (w && f) ? 1'b1 : (clr ? 1'b0 : o);
      add_row(0, w, clr, nr, nb, lvl == 8, lvl >= 7, lvl, no);
      b = nb; r = nr; f = (lvl == 8); o = no;
    end

    repeat (2) @(negedge wclock);
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge wclock);
      ri = rows[i];
      li = (i + LEAD < rows.size()) ? i + LEAD : rows.size() - 1;
      rp = rows[li].r;
      gray_rptr_in = to_gray(rp);
      w_en    = ri.rst ? 1'b0 : ri.w;
      clr_ovf = ri.rst ? 1'b0 : ri.clr;
      e.idx = i; e.eb = ri.eb; e.ef = ri.ef; e.eaf = ri.eaf; e.el = ri.el; e.eo = ri.eo;
      // A fresh reset assertion is sampled immediately and again at the next edge.
      if (ri.rst && wreset !== 1'b1) exp_q.push_back(e);
      exp_q.push_back(e);
      wreset = ri.rst;
    end
    @(negedge wclock);
    w_en = 1'b0; clr_ovf = 1'b0;
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge wclock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "timeout");
  end

endmodule
